// File: rtl/cheat_pgm_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cheat_pgm_loader_pkg
//  Purpose  : Shared constants and types for the cheat program loader:
//             record width, header validation mask, cheat-table slot numbers
//             and the record-assembler state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cheat_pgm_loader_pkg;

  // One queued record is {idx[2:0], word[31:0]}
  localparam int REC_W = 35;

  // A header byte is valid when every bit outside the slot index is zero
  localparam logic [7:0] HDR_MASK = 8'hF8;

  // Cheat-table slot numbers
  localparam logic [2:0] PATCH_MAX   = 3'd5;
  localparam logic [2:0] SLOT_MASK   = 3'd6;
  localparam logic [2:0] SLOT_GLOBAL = 3'd7;

  // Record assembler states
  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_B3   = 3'd1,
    ST_B2   = 3'd2,
    ST_B1   = 3'd3,
    ST_B0   = 3'd4,
    ST_SKIP = 3'd5
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/cheat_rec_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cheat_rec_fifo
//  Purpose  : Small synchronous FIFO holding complete cheat records. The head
//             entry is presented combinationally (zero when empty). A push is
//             accepted when not full, or when full but popping in the same
//             cycle (occupancy then stays the same).
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push/push_data  - write request and record
//             pop             - remove head (ignored when empty)
//             head_data       - current head record, 0 when empty
//             empty/full      - occupancy flags
//             count           - number of records held
//  Revision : 1.0  initial release
// ============================================================================
module cheat_rec_fifo
  import cheat_pgm_loader_pkg::*;
#(
  parameter int DEPTH = 2,   // 2 or 4; pointers rely on power-of-two wrap
  parameter int WIDTH = REC_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cheat_pgm_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cheat_pgm_loader
//  Purpose  : Assembles 5-byte cheat records (header + 32-bit word, MSB first)
//             from the MCU byte stream, queues them, and writes them into the
//             cheat table when the SNES side allows it.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             mcu_frame_start                - restart parsing, clear status
//             mcu_byte_we / mcu_byte_in      - MCU stream byte
//             snescmd_wr_strobe              - table busy with SNES write
//             SNES_cycle_start               - SNES bus cycle start strobe
//             pgm_we / pgm_idx / pgm_in      - cheat table write port
//             mcu_busy                       - record FIFO full
//             err_hdr / err_ovf              - sticky error flags
//             loaded_count                   - commits since frame start
//  Revision : 1.0  initial release
// ============================================================================
module cheat_pgm_loader
  import cheat_pgm_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mcu_frame_start,
  input  logic        mcu_byte_we,
  input  logic [7:0]  mcu_byte_in,
  input  logic        snescmd_wr_strobe,
  input  logic        SNES_cycle_start,
  output logic        pgm_we,
  output logic [2:0]  pgm_idx,
  output logic [31:0] pgm_in,
  output logic        mcu_busy,
  output logic        err_hdr,
  output logic        err_ovf,
  output logic [3:0]  loaded_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  asm_state_t       state;
  asm_state_t       state_eff;
  logic [2:0]       idx_q;
  logic [23:0]      word_q;
  logic [1:0]       skip_cnt;
  logic             rec_done;
  logic [REC_W-1:0] head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CW-1:0]    fifo_count;

  // A frame start wins over the current state, so a byte arriving in the
  // same cycle is parsed as a fresh header.
  assign state_eff = mcu_frame_start ? ST_HDR : state;
  assign rec_done  = mcu_byte_we & ~rst & (state_eff == ST_B0);

  cheat_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rec_done),
    .push_data ({idx_q, word_q, mcu_byte_in}),
    .pop       (pgm_we),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign pgm_idx  = head[34:32];
  assign pgm_in   = head[31:0];
  assign mcu_busy = (fifo_count == CW'(FIFO_DEPTH));

  // The table ignores program writes while a SNES command write is in
  // flight; global-enable records additionally wait for a bus cycle start.
  // Later records queue strictly behind the head.
  assign pgm_we = ~rst & ~fifo_empty & ~snescmd_wr_strobe
                & ((pgm_idx != SLOT_GLOBAL) | SNES_cycle_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HDR;
      idx_q    <= '0;
      word_q   <= '0;
      skip_cnt <= '0;
      err_hdr  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (mcu_frame_start) begin
        state   <= ST_HDR;
        err_hdr <= 1'b0;
        err_ovf <= 1'b0;
      end
      // Assignments below follow the frame-start clear so a bad header in
      // the same cycle still flags.
      if (mcu_byte_we) begin
        case (state_eff)
          ST_HDR: begin
            if ((mcu_byte_in & HDR_MASK) == 8'h00) begin
              idx_q <= mcu_byte_in[2:0];
              state <= ST_B3;
            end else begin
              err_hdr  <= 1'b1;
              skip_cnt <= 2'd0;
              state    <= ST_SKIP;
            end
          end
          ST_B3: begin
            word_q[23:16] <= mcu_byte_in;
            state         <= ST_B2;
          end
          ST_B2: begin
            word_q[15:8] <= mcu_byte_in;
            state        <= ST_B1;
          end
          ST_B1: begin
            word_q[7:0] <= mcu_byte_in;
            state       <= ST_B0;
          end
          ST_B0: begin
            // Push happens in the FIFO; a full FIFO not popping drops it.
            if (fifo_full & ~pgm_we) begin
              err_ovf <= 1'b1;
            end
            state <= ST_HDR;
          end
          ST_SKIP: begin
            if (skip_cnt == 2'd3) begin
              state <= ST_HDR;
            end else begin
              skip_cnt <= skip_cnt + 2'd1;
            end
          end
          default: state <= ST_HDR;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_count <= 4'd0;
    end else if (mcu_frame_start) begin
      loaded_count <= {3'b000, pgm_we};
    end else if (pgm_we && (loaded_count != 4'hF)) begin
      loaded_count <= loaded_count + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cheat_pgm_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cheat_pgm_loader
//  Purpose  : Directed self-checking bench for cheat_pgm_loader.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cheat_pgm_loader;

  logic        clk;
  logic        rst;
  logic        mcu_frame_start;
  logic        mcu_byte_we;
  logic [7:0]  mcu_byte_in;
  logic        snescmd_wr_strobe;
  logic        SNES_cycle_start;
  logic        pgm_we;
  logic [2:0]  pgm_idx;
  logic [31:0] pgm_in;
  logic        mcu_busy;
  logic        err_hdr;
  logic        err_ovf;
  logic [3:0]  loaded_count;

  int assertions = 0;
  int failures   = 0;

  int          we_cnt = 0;
  logic [2:0]  last_idx;
  logic [31:0] last_in;

  cheat_pgm_loader #(.FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .mcu_frame_start   (mcu_frame_start),
    .mcu_byte_we       (mcu_byte_we),
    .mcu_byte_in       (mcu_byte_in),
    .snescmd_wr_strobe (snescmd_wr_strobe),
    .SNES_cycle_start  (SNES_cycle_start),
    .pgm_we            (pgm_we),
    .pgm_idx           (pgm_idx),
    .pgm_in            (pgm_in),
    .mcu_busy          (mcu_busy),
    .err_hdr           (err_hdr),
    .err_ovf           (err_ovf),
    .loaded_count      (loaded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table writes are counted mid-cycle, where pgm_we is stable.
  always @(negedge clk) begin
    if (pgm_we === 1'b1) begin
      we_cnt   <= we_cnt + 1;
      last_idx <= pgm_idx;
      last_in  <= pgm_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mcu_byte_we = 1'b1;
    mcu_byte_in = b;
    tick();
    mcu_byte_we = 1'b0;
    mcu_byte_in = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", pgm_we); end
    assertions++; if (pgm_idx !== 3'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", pgm_idx); end
    assertions++; if (pgm_in !== 32'd0) begin failures++; $display("FAIL reset_in: got %h expected 0", pgm_in); end
    assertions++; if ({mcu_busy, err_hdr, err_ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {mcu_busy, err_hdr, err_ovf}); end
    assertions++; if (loaded_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", loaded_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_record();
    mcu_frame_start = 1'b1;
    tick();
    mcu_frame_start = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hEA);
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL basic_early_we: got %b expected 0", pgm_we); end
    send_byte(8'h5C);
    assertions++; if (pgm_we !== 1'b1) begin failures++; $display("FAIL basic_we: got %b expected 1", pgm_we); end
    assertions++; if (pgm_idx !== 3'd2) begin failures++; $display("FAIL basic_idx: got %0d expected 2", pgm_idx); end
    assertions++; if (pgm_in !== 32'h00FFEA5C) begin failures++; $display("FAIL basic_in: got %h expected 00ffea5c", pgm_in); end
    tick();
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL basic_we_after: got %b expected 0", pgm_we); end
    assertions++; if (loaded_count !== 4'd1) begin failures++; $display("FAIL basic_count: got %0d expected 1", loaded_count); end
  endtask

  task automatic test_bad_header();
    send_byte(8'h47);
    assertions++; if (err_hdr !== 1'b1) begin failures++; $display("FAIL badhdr_err: got %b expected 1", err_hdr); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL badhdr_we: got %b expected 0", pgm_we); end
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    assertions++; if ({pgm_we, pgm_idx} !== {1'b1, 3'd1}) begin failures++; $display("FAIL badhdr_next_we_idx: got %b expected 1001", {pgm_we, pgm_idx}); end
    assertions++; if (pgm_in !== 32'h12345678) begin failures++; $display("FAIL badhdr_next_in: got %h expected 12345678", pgm_in); end
    tick();
    assertions++; if (loaded_count !== 4'd2) begin failures++; $display("FAIL badhdr_count: got %0d expected 2", loaded_count); end
  endtask

  task automatic test_frame_restart();
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB);
    mcu_frame_start = 1'b1;
    send_byte(8'h05);
    mcu_frame_start = 1'b0;
    assertions++; if ({err_hdr, loaded_count} !== 5'd0) begin failures++; $display("FAIL restart_clear: got %b expected 00000", {err_hdr, loaded_count}); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    assertions++; if ({pgm_we, pgm_idx} !== {1'b1, 3'd5}) begin failures++; $display("FAIL restart_we_idx: got %b expected 1101", {pgm_we, pgm_idx}); end
    assertions++; if (pgm_in !== 32'h11223344) begin failures++; $display("FAIL restart_in: got %h expected 11223344", pgm_in); end
    tick();
  endtask

  task automatic test_wr_strobe();
    snescmd_wr_strobe = 1'b1;
    send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    assertions++; if ({pgm_we, pgm_idx} !== {1'b0, 3'd3}) begin failures++; $display("FAIL strobe_hold1: got %b expected 0011", {pgm_we, pgm_idx}); end
    tick();
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL strobe_hold2: got %b expected 0", pgm_we); end
    tick();
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL strobe_hold3: got %b expected 0", pgm_we); end
    snescmd_wr_strobe = 1'b0;
    #1;
    assertions++; if ({pgm_we, pgm_idx} !== {1'b1, 3'd3}) begin failures++; $display("FAIL strobe_release: got %b expected 1011", {pgm_we, pgm_idx}); end
    assertions++; if (pgm_in !== 32'hA1B2C3D4) begin failures++; $display("FAIL strobe_data: got %h expected a1b2c3d4", pgm_in); end
    tick();
    assertions++; if ({pgm_we, pgm_idx} !== 4'd0) begin failures++; $display("FAIL strobe_drained: got %b expected 0000", {pgm_we, pgm_idx}); end
  endtask

  task automatic test_slot_global();
    logic [7:0]  seq [10];
    int          c7 = -1;
    int          c0 = -1;
    logic        cs7 = 1'b0;
    logic [31:0] d7 = '0;
    logic [31:0] d0 = '0;
    seq = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h31, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 16; i++) begin
      mcu_byte_we      = (i < 10);
      mcu_byte_in      = (i < 10) ? seq[i] : 8'h00;
      SNES_cycle_start = ((i % 6) == 2);
      #2;
      if (pgm_we === 1'b1) begin
        if (pgm_idx === 3'd7) begin c7 = i; cs7 = SNES_cycle_start; d7 = pgm_in; end
        else if (pgm_idx === 3'd0) begin c0 = i; d0 = pgm_in; end
      end
      tick();
    end
    mcu_byte_we = 1'b0; mcu_byte_in = 8'h00; SNES_cycle_start = 1'b0;
    assertions++; if (c7 != 8) begin failures++; $display("FAIL slot7_cycle: got %0d expected 8", c7); end
    assertions++; if ({cs7, d7} !== {1'b1, 32'h00000031}) begin failures++; $display("FAIL slot7_data: got %b/%h expected 1/00000031", cs7, d7); end
    assertions++; if (c0 != 10) begin failures++; $display("FAIL slot0_cycle: got %0d expected 10", c0); end
    assertions++; if (d0 !== 32'h11223344) begin failures++; $display("FAIL slot0_data: got %h expected 11223344", d0); end
  endtask

  task automatic test_overflow();
    int n0;
    mcu_frame_start = 1'b1;
    tick();
    mcu_frame_start = 1'b0;
    snescmd_wr_strobe = 1'b1;
    send_byte(8'h04); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    assertions++; if (mcu_busy !== 1'b0) begin failures++; $display("FAIL ovf_busy1: got %b expected 0", mcu_busy); end
    send_byte(8'h05); send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    assertions++; if ({mcu_busy, err_ovf} !== 2'b10) begin failures++; $display("FAIL ovf_busy2: got %b expected 10", {mcu_busy, err_ovf}); end
    send_byte(8'h06); send_byte(8'h09); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    assertions++; if ({mcu_busy, err_ovf} !== 2'b11) begin failures++; $display("FAIL ovf_drop: got %b expected 11", {mcu_busy, err_ovf}); end
    n0 = we_cnt;
    snescmd_wr_strobe = 1'b0;
    #1;
    assertions++; if ({pgm_we, pgm_idx} !== {1'b1, 3'd4}) begin failures++; $display("FAIL ovf_first: got %b expected 1100", {pgm_we, pgm_idx}); end
    repeat (4) tick();
    assertions++; if (we_cnt - n0 != 2) begin failures++; $display("FAIL ovf_we_count: got %0d expected 2", we_cnt - n0); end
    assertions++; if ({last_idx, last_in} !== {3'd5, 32'h05060708}) begin failures++; $display("FAIL ovf_last: got %0d/%h expected 5/05060708", last_idx, last_in); end
    assertions++; if ({mcu_busy, err_ovf, loaded_count} !== {2'b01, 4'd2}) begin failures++; $display("FAIL ovf_final: got %b expected 010010", {mcu_busy, err_ovf, loaded_count}); end
  endtask

  task automatic test_reset_mid();
    snescmd_wr_strobe = 1'b1;
    send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    rst = 1'b1;
    snescmd_wr_strobe = 1'b0;
    #1;
    assertions++; if (pgm_we !== 1'b0) begin failures++; $display("FAIL rstmid_we: got %b expected 0", pgm_we); end
    tick();
    rst = 1'b0;
    #1;
    assertions++; if ({pgm_we, pgm_idx, pgm_in} !== 36'd0) begin failures++; $display("FAIL rstmid_port: got %b/%0d/%h expected 0", pgm_we, pgm_idx, pgm_in); end
    assertions++; if ({mcu_busy, err_hdr, err_ovf, loaded_count} !== 7'd0) begin failures++; $display("FAIL rstmid_status: got %b expected 0000000", {mcu_busy, err_hdr, err_ovf, loaded_count}); end
    send_byte(8'h03); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    assertions++; if ({pgm_we, pgm_idx, pgm_in} !== {1'b1, 3'd3, 32'hDEADBEEF}) begin failures++; $display("FAIL rstmid_fresh: got %b/%0d/%h expected 1/3/deadbeef", pgm_we, pgm_idx, pgm_in); end
    tick();
    assertions++; if ({pgm_we, loaded_count} !== {1'b0, 4'd1}) begin failures++; $display("FAIL rstmid_count: got %b expected 00001", {pgm_we, loaded_count}); end
  endtask

  initial begin
    rst               = 1'b1;
    mcu_frame_start   = 1'b0;
    mcu_byte_we       = 1'b0;
    mcu_byte_in       = 8'h00;
    snescmd_wr_strobe = 1'b0;
    SNES_cycle_start  = 1'b0;
    test_reset();
    test_basic_record();
    test_bad_header();
    test_frame_restart();
    test_wr_strobe();
    test_slot_global();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
`default_nettype wire
